riscv_multicycle_control: RTL

Main controller for the multi-cycle RISC-V core generation. It is a state machine that sequences fetch, decode, execute, memory and writeback over several clocks on a shared datapath. It adds a variable-latency memory handshake with optional timeout, illegal-opcode trapping and a retired-instruction counter. It sits between the instruction register and the shared datapath muxes and enables.

---
 rtl/riscv_multicycle_control_if.sv | 10 +
 rtl/riscv_multicycle_control.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_multicycle_control_if.sv
// Memory-port handshake between the multi-cycle controller (master) and the shared memory (slave).
interface riscv_multicycle_control_if;
   logic mem_req_o;
   logic mem_write_o;
   logic adr_src_o;
   logic mem_ready_i;

   modport master (output mem_req_o, output mem_write_o, output adr_src_o, input mem_ready_i);
   modport slave  (input mem_req_o, input mem_write_o, input adr_src_o, output mem_ready_i);
endinterface

// File: rtl/riscv_multicycle_control.sv
// Multi-cycle RISC-V main controller: sequences fetch/decode/execute/memory/writeback on a shared
// datapath, with a variable-latency memory handshake, optional timeout, trapping and retire counting.
module riscv_multicycle_control #(
   parameter bit MEM_WAIT_EN    = 1'b1,
   parameter int TIMEOUT_CYCLES = 0,
   parameter int COUNTER_WIDTH  = 32
) (
   input  logic                       clk,
   input  logic                       reset,
   riscv_multicycle_control_if.master mem_if,
   input  logic [6:0]                 opcode_i,
   input  logic [2:0]                 funct3_i,
   input  logic                       funct7_5_i,
   input  logic                       zero_i,
   output logic                       ir_write_o,
   output logic                       pc_write_o,
   output logic                       reg_write_o,
   output logic [1:0]                 alu_src_a_o,
   output logic [1:0]                 alu_src_b_o,
   output logic [1:0]                 result_src_o,
   output logic [2:0]                 imm_src_o,
   output logic [3:0]                 alu_operation_o,
   output logic                       illegal_o,
   output logic                       timeout_o,
   output logic [COUNTER_WIDTH-1:0]   instret_o
);
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_SLT  = 4'd5;
   localparam logic [3:0] ALU_SLL  = 4'd6;
   localparam logic [3:0] ALU_SRL  = 4'd7;
   localparam logic [3:0] ALU_SRA  = 4'd8;
   localparam logic [3:0] ALU_SLTU = 4'd9;

   localparam logic [2:0] IMM_I = 3'd0;
   localparam logic [2:0] IMM_S = 3'd1;
   localparam logic [2:0] IMM_B = 3'd2;
   localparam logic [2:0] IMM_J = 3'd3;
   localparam logic [2:0] IMM_U = 3'd4;

   localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
   localparam int WAIT_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = TIMEOUT_EN ? WAIT_W'(TIMEOUT_CYCLES - 1) : '0;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_EXECR    = 4'd2,
      S_EXECI    = 4'd3,
      S_ALUWB    = 4'd4,
      S_MEMADR   = 4'd5,
      S_MEMREAD  = 4'd6,
      S_MEMWB    = 4'd7,
      S_MEMWRITE = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10,
      S_JALR1    = 4'd11,
      S_JALR2    = 4'd12,
      S_LUI      = 4'd13,
      S_TRAP     = 4'd14
   } state_e;

   state_e                   state_r;
   logic [WAIT_W-1:0]        wait_cnt_r;
   logic                     illegal_r;
   logic                     timeout_r;
   logic [COUNTER_WIDTH-1:0] instret_r;

   logic ready_eff_s;
   logic mem_state_s;
   logic mem_wait_s;
   logic timeout_hit_s;
   logic branch_legal_s;
   logic branch_take_s;
   logic retire_s;
   logic mem_req_s;
   logic mem_write_s;
   logic ir_write_s;
   logic pc_write_s;
   logic reg_write_s;

   // funct7_5 only means SUB for register-register ops; for immediates it is an immediate bit
   function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic f7_5, input logic reg_form);
      logic [3:0] op;
      case (f3)
         3'b000:  op = (f7_5 && reg_form) ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = f7_5 ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         3'b111:  op = ALU_AND;
         default: op = ALU_ADD;
      endcase
      return op;
   endfunction

   assign ready_eff_s    = (MEM_WAIT_EN == 1'b0) || mem_if.mem_ready_i;
   assign mem_state_s    = (state_r == S_FETCH) || (state_r == S_MEMREAD) || (state_r == S_MEMWRITE);
   assign mem_wait_s     = TIMEOUT_EN && mem_state_s && !ready_eff_s;
   assign timeout_hit_s  = mem_wait_s && (wait_cnt_r == WAIT_LAST);
   assign branch_legal_s = (funct3_i == 3'b000) || (funct3_i == 3'b001);
   assign branch_take_s  = ((funct3_i == 3'b000) && zero_i) || ((funct3_i == 3'b001) && !zero_i);

   // Immediate format follows the opcode in every state
   always_comb begin
      imm_src_o = IMM_I;
      case (opcode_i)
         OP_STORE:  imm_src_o = IMM_S;
         OP_BRANCH: imm_src_o = IMM_B;
         OP_JAL:    imm_src_o = IMM_J;
         OP_LUI:    imm_src_o = IMM_U;
         default:   imm_src_o = IMM_I;
      endcase
   end

   // Instruction retires in its final state; trapping instructions never reach this point
   always_comb begin
      retire_s = 1'b0;
      case (state_r)
         S_ALUWB, S_MEMWB, S_LUI: retire_s = 1'b1;
         S_MEMWRITE:              retire_s = ready_eff_s;
         S_BRANCH:                retire_s = branch_legal_s;
         default:                 retire_s = 1'b0;
      endcase
   end

   // Datapath control decode from the current state
   always_comb begin
      mem_req_s       = 1'b0;
      mem_write_s     = 1'b0;
      mem_if.adr_src_o = 1'b0;
      ir_write_s      = 1'b0;
      pc_write_s      = 1'b0;
      reg_write_s     = 1'b0;
      alu_src_a_o     = 2'd0;
      alu_src_b_o     = 2'd0;
      result_src_o    = 2'd0;
      alu_operation_o = ALU_ADD;
      case (state_r)
         S_FETCH: begin
            mem_req_s    = 1'b1;
            ir_write_s   = ready_eff_s;
            pc_write_s   = ready_eff_s;
            alu_src_b_o  = 2'd2;
            result_src_o = 2'd2;
         end
         S_DECODE: begin
            alu_src_a_o = 2'd1;
            alu_src_b_o = 2'd1;
         end
         S_EXECR: begin
            alu_src_a_o     = 2'd2;
            alu_operation_o = alu_decode(funct3_i, funct7_5_i, 1'b1);
         end
         S_EXECI: begin
            alu_src_a_o     = 2'd2;
            alu_src_b_o     = 2'd1;
            alu_operation_o = alu_decode(funct3_i, funct7_5_i, 1'b0);
         end
         S_ALUWB:  reg_write_s = 1'b1;
         S_MEMADR, S_JALR1: begin
            alu_src_a_o = 2'd2;
            alu_src_b_o = 2'd1;
         end
         S_MEMREAD: begin
            mem_req_s        = 1'b1;
            mem_if.adr_src_o = 1'b1;
         end
         S_MEMWB: begin
            reg_write_s  = 1'b1;
            result_src_o = 2'd1;
         end
         S_MEMWRITE: begin
            mem_req_s        = 1'b1;
            mem_write_s      = 1'b1;
            mem_if.adr_src_o = 1'b1;
         end
         S_BRANCH: begin
            pc_write_s      = branch_take_s;
            alu_src_a_o     = 2'd2;
            alu_operation_o = ALU_SUB;
         end
         S_JAL, S_JALR2: begin
            pc_write_s  = 1'b1;
            alu_src_a_o = 2'd1;
            alu_src_b_o = 2'd2;
         end
         S_LUI: begin
            reg_write_s  = 1'b1;
            result_src_o = 2'd3;
         end
         default: begin
            pc_write_s = 1'b0;
         end
      endcase
   end

   // Reset gates enables combinationally so a request drops in the same cycle
   assign mem_if.mem_req_o   = mem_req_s   && !reset;
   assign mem_if.mem_write_o = mem_write_s && !reset;
   assign ir_write_o         = ir_write_s  && !reset;
   assign pc_write_o         = pc_write_s  && !reset;
   assign reg_write_o        = reg_write_s && !reset;
   assign illegal_o          = illegal_r;
   assign timeout_o          = timeout_r;
   assign instret_o          = instret_r;

   // State sequencing, memory wait counting, sticky trap flags and retire counter
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= S_FETCH;
         wait_cnt_r <= '0;
         illegal_r  <= 1'b0;
         timeout_r  <= 1'b0;
         instret_r  <= '0;
      end else begin
         wait_cnt_r <= (mem_wait_s && !timeout_hit_s) ? wait_cnt_r + WAIT_W'(1) : '0;
         if (retire_s) begin
            instret_r <= instret_r + COUNTER_WIDTH'(1);
         end
         if (timeout_hit_s) begin
            state_r   <= S_TRAP;
            timeout_r <= 1'b1;
            illegal_r <= 1'b1;
         end else begin
            case (state_r)
               S_FETCH:    state_r <= ready_eff_s ? S_DECODE : S_FETCH;
               S_DECODE: begin
                  case (opcode_i)
                     OP_RTYPE:          state_r <= S_EXECR;
                     OP_ITYPE:          state_r <= S_EXECI;
                     OP_LOAD, OP_STORE: state_r <= S_MEMADR;
                     OP_BRANCH:         state_r <= S_BRANCH;
                     OP_JAL:            state_r <= S_JAL;
                     OP_JALR:           state_r <= S_JALR1;
                     OP_LUI:            state_r <= S_LUI;
                     default: begin
                        state_r   <= S_TRAP;
                        illegal_r <= 1'b1;
                     end
                  endcase
               end
               S_EXECR, S_EXECI:         state_r <= S_ALUWB;
               S_ALUWB, S_MEMWB, S_LUI:  state_r <= S_FETCH;
               S_MEMADR: begin
                  if (opcode_i == OP_LOAD) begin
                     state_r <= S_MEMREAD;
                  end else if (opcode_i == OP_STORE) begin
                     state_r <= S_MEMWRITE;
                  end else begin
                     state_r   <= S_TRAP;
                     illegal_r <= 1'b1;
                  end
               end
               S_MEMREAD:  state_r <= ready_eff_s ? S_MEMWB : S_MEMREAD;
               S_MEMWRITE: state_r <= ready_eff_s ? S_FETCH : S_MEMWRITE;
               S_BRANCH: begin
                  if (branch_legal_s) begin
                     state_r <= S_FETCH;
                  end else begin
                     state_r   <= S_TRAP;
                     illegal_r <= 1'b1;
                  end
               end
               S_JAL, S_JALR2: state_r <= S_ALUWB;
               S_JALR1:        state_r <= S_JALR2;
               S_TRAP:         state_r <= S_TRAP;
               default: begin
                  state_r   <= S_TRAP;
                  illegal_r <= 1'b1;
               end
            endcase
         end
      end
   end
endmodule
